// File: rtl/dev_intctl.sv
// Memory-mapped interrupt controller: edge-captured pending bits, enable mask,
// global enable and a fixed-priority IDLE/REQ/SERVICE handshake with the CPU.
module dev_intctl #(
  parameter int               DBITS   = 32,
  parameter int               NSRC    = 4,
  parameter logic [DBITS-1:0] IEADDR  = 32'hF0000100,
  parameter logic [DBITS-1:0] IPADDR  = 32'hF0000104,
  parameter logic [DBITS-1:0] CTLADDR = 32'hF0000108,
  parameter logic [DBITS-1:0] EOIADDR = 32'hF000010C
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ABUS,
  input  logic [DBITS-1:0] DBUS_IN,
  output logic [DBITS-1:0] DBUS_OUT,
  input  logic             WE,
  input  logic [NSRC-1:0]  IRQ_SRC,
  output logic             INTR,
  input  logic             INTA,
  output logic [2:0]       INTNUM
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateT;

  stateT           stateReg;
  logic [NSRC-1:0] ieReg;
  logic [NSRC-1:0] ipReg;
  logic [NSRC-1:0] prevReg;
  logic            gieReg;
  logic [2:0]      idReg;

  logic            wrIe, wrIp, wrCtl, wrEoi;
  logic [NSRC-1:0] riseVec;
  logic [NSRC-1:0] activeVec;
  logic [NSRC-1:0] idMask;
  logic [NSRC-1:0] clrVec;
  logic [NSRC-1:0] ipNext;
  logic [2:0]      prioIdx;
  logic            ieOfId;
  logic            ackNow;
  logic [DBITS-1:0] readData;

  assign wrIe  = WE && (ABUS == IEADDR);
  assign wrIp  = WE && (ABUS == IPADDR);
  assign wrCtl = WE && (ABUS == CTLADDR);
  assign wrEoi = WE && (ABUS == EOIADDR);

  assign riseVec   = IRQ_SRC & ~prevReg;
  assign activeVec = ipReg & ieReg;
  assign ackNow    = (stateReg == REQ) && INTA;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : gIdDecode
      assign idMask[gi] = (idReg == 3'(gi));
    end
  endgenerate

  assign ieOfId = |(ieReg & idMask);

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    prioIdx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (activeVec[i]) prioIdx = 3'(i);
    end
  end

  // A new edge in the same cycle as a clear (bus W1C or acknowledge) keeps the bit set.
  always_comb begin
    clrVec = '0;
    if (wrIp)   clrVec = clrVec | DBUS_IN[NSRC-1:0];
    if (ackNow) clrVec = clrVec | idMask;
    ipNext = (ipReg & ~clrVec) | riseVec;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ieReg    <= '0;
      ipReg    <= '0;
      prevReg  <= '0;
      gieReg   <= 1'b0;
      idReg    <= 3'd0;
      stateReg <= IDLE;
    end else begin
      prevReg <= IRQ_SRC;
      ipReg   <= ipNext;
      if (wrIe)  ieReg  <= DBUS_IN[NSRC-1:0];
      if (wrCtl) gieReg <= DBUS_IN[0];
      case (stateReg)
        IDLE: begin
          if (gieReg && (|activeVec)) begin
            stateReg <= REQ;
            idReg    <= prioIdx;
          end
        end
        REQ: begin
          if (INTA)                   stateReg <= SERVICE;
          else if (!gieReg || !ieOfId) stateReg <= IDLE;
        end
        SERVICE: begin
          if (wrEoi) stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  always_comb begin
    readData = '0;
    if (!WE) begin
      if (ABUS == IEADDR) begin
        readData[NSRC-1:0] = ieReg;
      end else if (ABUS == IPADDR) begin
        readData[NSRC-1:0] = ipReg;
      end else if (ABUS == CTLADDR) begin
        readData[6:4] = idReg;
        readData[1]   = (stateReg == SERVICE);
        readData[0]   = gieReg;
      end
    end
  end

  assign DBUS_OUT = readData;
  assign INTR     = (stateReg == REQ);
  assign INTNUM   = idReg;

  // Upper write-data bits are never stored.
  logic unusedBits;
  assign unusedBits = &{1'b0, DBUS_IN[DBITS-1:NSRC]};

endmodule
